// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: the last_src encoding
// and the default reset and exception vectors.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_RST = 3'd0,
      SRC_SEQ = 3'd1,
      SRC_BR  = 3'd2,
      SRC_JMP = 3'd3,
      SRC_RET = 3'd4,
      SRC_EXC = 3'd5
   } src_e;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. ptr always indexes the current top entry. A push
// into a full stack overwrites the oldest entry and sets the sticky ovf flag.
module ras_stack #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             ovf
);

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    ptr;
   logic [CW-1:0]    count;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign top    = mem[ptr];
   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (push && !do_pop) begin
         ptr <= ptr + 1'b1;
         if (count == FULL_CNT) ovf <= 1'b1;
         else count <= count + 1'b1;
      end else if (do_pop && !push) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

   // Simultaneous pop and push reuses the popped slot, so pointer and count stay put.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         if (do_pop) mem[ptr] <= push_data;
         else mem[ptr + 1'b1] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority redirect mux (exc > hold > ret > jump >
// branch > sequential) in front of the pc register, with a RAS for returns.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      STEP      = 1,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
   parameter int unsigned      RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             exc,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] ret_fallback,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic [2:0]       last_src,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_miss,
   output logic             ras_ovf
);

   src_e             src_q;
   logic [WIDTH-1:0] ras_top;
   logic             ras_push;
   logic             ras_pop;

   assign pc_seq   = pc + WIDTH'(STEP);
   assign last_src = src_q;
   assign ras_push = en && !exc && call;
   assign ras_pop  = en && !exc && ret;

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_seq),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .ovf       (ras_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_VEC;
         src_q    <= SRC_RST;
         ras_miss <= 1'b0;
      end else begin
         ras_miss <= 1'b0;
         if (exc) begin
            pc    <= EXC_VEC;
            src_q <= SRC_EXC;
         end else if (en) begin
            if (ret) begin
               pc       <= ras_empty ? ret_fallback : ras_top;
               src_q    <= SRC_RET;
               ras_miss <= ras_empty;
            end else if (jump) begin
               pc    <= jump_target;
               src_q <= SRC_JMP;
            end else if (br_taken) begin
               pc    <= br_target;
               src_q <= SRC_BR;
            end else begin
               pc    <= pc_seq;
               src_q <= SRC_SEQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance and an 8-bit instance share
// the control inputs; expected values are hand-computed constants.
module tb_pc_sequencer;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, en, exc, br_taken, jump, call, ret;
   logic [31:0] br_target, jump_target, ret_fallback;

   logic [31:0] pc, pc_seq;
   logic [2:0]  last_src;
   logic        ras_empty, ras_full, ras_miss, ras_ovf;

   logic [7:0]  pc8, pc_seq8;
   logic [2:0]  last_src8;
   logic        ras_empty8, ras_full8, ras_miss8, ras_ovf8;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(32), .STEP(1), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .exc(exc),
      .br_taken(br_taken), .br_target(br_target),
      .jump(jump), .jump_target(jump_target),
      .call(call), .ret(ret), .ret_fallback(ret_fallback),
      .pc(pc), .pc_seq(pc_seq), .last_src(last_src),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss), .ras_ovf(ras_ovf)
   );

   pc_sequencer #(.WIDTH(8), .STEP(1), .RESET_VEC(8'h0), .EXC_VEC(8'h80), .RAS_DEPTH(4)) dut8 (
      .clk(clk), .rst(rst), .en(en), .exc(exc),
      .br_taken(br_taken), .br_target(br_target[7:0]),
      .jump(jump), .jump_target(jump_target[7:0]),
      .call(call), .ret(ret), .ret_fallback(ret_fallback[7:0]),
      .pc(pc8), .pc_seq(pc_seq8), .last_src(last_src8),
      .ras_empty(ras_empty8), .ras_full(ras_full8), .ras_miss(ras_miss8), .ras_ovf(ras_ovf8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks: one clock edge, then sample 1 ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; exc = 1'b0; br_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
      br_target = '0; jump_target = '0; ret_fallback = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic jump_to(input logic [31:0] tgt);
      en = 1'b1; jump = 1'b1; jump_target = tgt;
      step();
      jump = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      do_reset();
      check("rst_pc", pc, 32'd0);
      check("rst_src", {29'd0, last_src}, {29'd0, SRC_RST});
      check("rst_empty", {31'd0, ras_empty}, 32'd1);
      check("rst_full", {31'd0, ras_full}, 32'd0);
      check("rst_miss", {31'd0, ras_miss}, 32'd0);
      check("rst_ovf", {31'd0, ras_ovf}, 32'd0);

      // sequential run then stall
      en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check("seq_pc", pc, 32'(i));
         check("seq_src", {29'd0, last_src}, {29'd0, SRC_SEQ});
      end
      en = 1'b0;
      step();
      step();
      check("hold_pc", pc, 32'd3);
      check("hold_src", {29'd0, last_src}, {29'd0, SRC_SEQ});
      check("hold_pc_seq", pc_seq, 32'd4);

      // redirect priority
      jump_to(32'd10);
      check("jmp_pc", pc, 32'd10);
      en = 1'b1; br_taken = 1'b1; br_target = 32'd40; jump = 1'b1; jump_target = 32'd80;
      step();
      check("jmp_over_br_pc", pc, 32'd80);
      check("jmp_over_br_src", {29'd0, last_src}, {29'd0, SRC_JMP});
      jump = 1'b0;
      step();
      check("br_pc", pc, 32'd40);
      check("br_src", {29'd0, last_src}, {29'd0, SRC_BR});
      br_taken = 1'b0;
      exc = 1'b1; jump = 1'b1; jump_target = 32'd20;
      step();
      check("exc_over_jmp_pc", pc, 32'h80);
      check("exc_src", {29'd0, last_src}, {29'd0, SRC_EXC});
      exc = 1'b0;
      jump_to(32'd5);
      check("pre_exc_pc", pc, 32'd5);
      en = 1'b0; exc = 1'b1;
      step();
      check("exc_stall_pc", pc, 32'h80);
      exc = 1'b0;

      // call + jump, return, empty return
      jump_to(32'd5);
      en = 1'b1; call = 1'b1; jump = 1'b1; jump_target = 32'd20;
      step();
      call = 1'b0; jump = 1'b0;
      check("jal_pc", pc, 32'd20);
      check("jal_not_empty", {31'd0, ras_empty}, 32'd0);
      ret = 1'b1; ret_fallback = 32'd99;
      step();
      check("ret_pc", pc, 32'd6);
      check("ret_src", {29'd0, last_src}, {29'd0, SRC_RET});
      check("ret_empty", {31'd0, ras_empty}, 32'd1);
      check("ret_no_miss", {31'd0, ras_miss}, 32'd0);
      step();
      check("miss_pc", pc, 32'd99);
      check("miss_pulse", {31'd0, ras_miss}, 32'd1);
      ret = 1'b0;
      step();
      check("miss_clear", {31'd0, ras_miss}, 32'd0);
      check("after_miss_pc", pc, 32'd100);

      // call and ret together swap the top entry
      call = 1'b1;
      step();
      check("push_pc", pc, 32'd101);
      ret = 1'b1;
      step();
      check("swap_pc", pc, 32'd101);
      check("swap_not_empty", {31'd0, ras_empty}, 32'd0);
      call = 1'b0;
      step();
      check("swap_ret_pc", pc, 32'd102);
      check("swap_ret_empty", {31'd0, ras_empty}, 32'd1);
      ret = 1'b0;

      // overflow: five pushes into a four-deep stack
      do_reset();
      en = 1'b1; call = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(32'(i + 1));
         step();
      end
      call = 1'b0;
      void'(exp_q.pop_front());
      check("ovf_full", {31'd0, ras_full}, 32'd1);
      check("ovf_flag", {31'd0, ras_ovf}, 32'd1);
      ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ovf_ret_pc", pc, exp_q.pop_back());
      end
      ret = 1'b0;
      check("ovf_drained", {31'd0, ras_empty}, 32'd1);
      check("ovf_sticky", {31'd0, ras_ovf}, 32'd1);

      // reset in the middle of a call sequence
      call = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; call = 1'b0;
      check("midrst_pc", pc, 32'd0);
      check("midrst_empty", {31'd0, ras_empty}, 32'd1);
      check("midrst_ovf", {31'd0, ras_ovf}, 32'd0);
      step();
      check("post_rst_pc", pc, 32'd1);

      // width wrap on the 8-bit instance
      jump_to(32'hFF);
      check("w8_pc_ff", {24'd0, pc8}, 32'hFF);
      check("w8_pc_seq_wrap", {24'd0, pc_seq8}, 32'h00);
      step();
      check("w8_wrap_pc", {24'd0, pc8}, 32'h00);
      check("w32_no_wrap_pc", pc, 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the MIPS fetch stage. It holds the current fetch address and advances it by a configurable step. It selects redirects from exception, return, jump and branch sources under a fixed priority. It keeps a small circular return-address stack (RAS) so that returns can be redirected without waiting on the register file.

## Interface
Parameters:
- WIDTH, 32: PC width in bits.
- STEP, 1: sequential increment (1 = word-addressed memory, 4 = byte-addressed).
- RESET_VEC, 0: PC value loaded on reset.
- EXC_VEC, 32'h80: PC value loaded on exception (truncated to WIDTH).
- RAS_DEPTH, 4: return-stack entries, power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance enable; low = hold (stall).
- exc  in  1  exception request; acts even when en=0.
- br_taken  in  1  branch resolved taken.
- br_target  in  WIDTH  branch destination.
- jump  in  1  unconditional jump.
- jump_target  in  WIDTH  jump destination.
- call  in  1  push pc+STEP onto RAS (jal/jalr).
- ret  in  1  return (jr $ra): pop RAS and redirect.
- ret_fallback  in  WIDTH  target used when ret finds RAS empty.
- pc  out  WIDTH  current fetch address (registered).
- pc_seq  out  WIDTH  pc+STEP (combinational).
- last_src  out  3  source that produced current pc (pc_pkg encoding).
- ras_empty  out  1  RAS count = 0.
- ras_full  out  1  RAS count = RAS_DEPTH.
- ras_miss  out  1  one-cycle pulse: ret serviced from ret_fallback.
- ras_ovf  out  1  sticky: a push overwrote the oldest entry.

## Operation
- Next-PC priority, evaluated each edge: rst > exc > (en=0: hold) > ret > jump > br_taken > sequential.
- rst: pc=RESET_VEC, last_src=SRC_RST, RAS count=0, pointer=0, ras_ovf=0, ras_miss=0.
- exc: pc=EXC_VEC, last_src=SRC_EXC. call and ret are ignored that cycle. RAS contents are unchanged.
- en=0 without exc: pc, RAS and last_src hold. call and ret are ignored. ras_miss=0.
- ret with count>0: pc=top entry, pointer decrements, count−1, last_src=SRC_RET.
- ret with count=0: pc=ret_fallback, ras_miss=1 for one cycle, last_src=SRC_RET.
- call (en=1, no exc): writes pc+STEP at pointer+1, pointer increments mod RAS_DEPTH, count saturates at RAS_DEPTH.
- call when full: the oldest entry is overwritten and ras_ovf is set.
- call together with jump (jal): the push and the jump redirect both occur.
- call and ret together: the ret target is the old top. The popped slot is then replaced by the push, so count is unchanged. If count=0, ret uses the fallback and the push leaves count=1.
- Arithmetic: pc+STEP is modulo 2^WIDTH, so all-ones+1 wraps to 0 silently.

## Timing
- All redirects are visible on pc one cycle after the edge at which they are sampled. There are no bubbles inside the block.
- pc_seq follows pc combinationally in the same cycle.
- ras_empty and ras_full reflect the registered count.
- A pop followed by a push in consecutive cycles needs no turnaround.
- Reset mid-operation discards pending requests. The first post-reset edge with en=1 gives pc=RESET_VEC+STEP.
- Outputs after reset: pc=RESET_VEC, last_src=SRC_RST, ras_empty=1, ras_full=0, ras_miss=0, ras_ovf=0.

## Structure
- Shared package pc_pkg holds the last_src encoding: SRC_RST=0, SRC_SEQ=1, SRC_BR=2, SRC_JMP=3, SRC_RET=4, SRC_EXC=5. It also holds the default RESET_VEC and EXC_VEC constants.
- Sub-module ras_stack (parameters WIDTH, RAS_DEPTH) provides the circular buffer: push/pop/data/count/full/empty/ovf.
- The top level contains the priority mux and the pc register only.

## Test plan
- Reset then 3 cycles en=1, STEP=1 -> pc 0,1,2,3, last_src=SRC_SEQ; en=0 for 2 cycles -> pc holds at 3.
- pc=10, br_taken=1 and jump=1 with br_target=40, jump_target=80 -> pc=80; exc the same cycle as jump -> pc=EXC_VEC, and exc with en=0 -> pc=EXC_VEC.
- From pc=5, call+jump to 20 -> pc=20 with RAS top=6; then ret -> pc=6, ras_empty=1; then ret with ret_fallback=99 -> pc=99, ras_miss pulses once.
- RAS_DEPTH=4, five calls from pcs 0..4 -> ras_full=1, ras_ovf=1; four rets -> pcs 5,4,3,2 (entry 1 lost).
- WIDTH=8, pc=8'hFF, sequential step -> pc=8'h00; rst asserted mid-call sequence -> pc=RESET_VEC, ras_empty=1, ras_ovf=0.
